// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: armed/triggered capture of CPU (pc, result) samples into a FWFT FIFO.
// Ports: clk/reset (sync, active-high); arm/trig_en/trig_pc/stop control the capture;
// cap_valid/cap_pc/cap_result carry the sample stream; rd_ready/rd_valid/rd_pc/rd_result
// form the first-word-fall-through read side; count, state and sticky dropped report status.
module cpu_trace_buffer #(
  parameter int W = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          trig_en,
  input  logic [W-1:0]  trig_pc,
  input  logic          stop,
  input  logic          cap_valid,
  input  logic [W-1:0]  cap_pc,
  input  logic [W-1:0]  cap_result,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [W-1:0]  rd_pc,
  output logic [W-1:0]  rd_result,
  output logic [AW:0]   count,
  output logic [1:0]    state,
  output logic          dropped
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = FULL - 1'b1;
  state_t st;
  logic [W-1:0] mem_pc [DEPTH];
  logic [W-1:0] mem_res [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic pop, wr;
  assign state = st;
  always_comb begin
    rd_valid = count != '0;
    pop = rd_valid && rd_ready;
    // ARMED writes only the matching sample and never on a stop cycle
    wr = cap_valid && count != FULL && (st == CAPTURE || (st == ARMED && !stop && cap_pc == trig_pc));
    rd_pc = rd_valid ? mem_pc[rptr] : '0;
    rd_result = rd_valid ? mem_res[rptr] : '0;
  end
  always_ff @(posedge clk)
    if (wr) begin
      mem_pc[wptr] <= cap_pc;
      mem_res[wptr] <= cap_result;
    end
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      dropped <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      case (st)
        IDLE: if (arm) begin
          st <= trig_en ? ARMED : CAPTURE;
          dropped <= 1'b0;
        end
        ARMED: st <= stop ? DONE : wr ? CAPTURE : ARMED;
        CAPTURE: if (stop || (wr && !pop && count == LAST)) st <= DONE;
        DONE: begin
          if (cap_valid) dropped <= 1'b1;
          if (count == '0) st <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed vector table plus hand sequences for cpu_trace_buffer (W=16, DEPTH=4).
module tb_cpu_trace_buffer;
  logic clk = 0, reset = 0, arm = 0, trig_en = 0, stop = 0, cap_valid = 0, rd_ready = 0;
  logic [15:0] trig_pc = 0, cap_pc = 0, cap_result = 0;
  logic rd_valid, dropped;
  logic [15:0] rd_pc, rd_result;
  logic [2:0] count;
  logic [1:0] state;
  int total = 0, bad = 0;
  cpu_trace_buffer #(.W(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .stop(stop),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_result(cap_result), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_result(rd_result), .count(count), .state(state),
    .dropped(dropped)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, a, te;
    logic [15:0] tp;
    logic s, c;
    logic [15:0] p;
    logic rr;
    logic [1:0] es;
    logic [2:0] ec;
    logic ed, ev;
    logic [15:0] epc;
  } vec_t;
  vec_t v[$];
  function automatic logic [15:0] res_of(input logic [15:0] p);
    return p ^ 16'h5A5A;
  endfunction
  task automatic add(input logic r, a, te, input logic [15:0] tp, input logic s, c,
                     input logic [15:0] p, input logic rr, input logic [1:0] es,
                     input logic [2:0] ec, input logic ed, ev, input logic [15:0] epc);
    vec_t x;
    x.r = r; x.a = a; x.te = te; x.tp = tp; x.s = s; x.c = c; x.p = p; x.rr = rr;
    x.es = es; x.ec = ec; x.ed = ed; x.ev = ev; x.epc = epc;
    v.push_back(x);
  endtask
  task automatic drive(input logic r, a, te, input logic [15:0] tp, input logic s, c,
                       input logic [15:0] p, input logic rr);
    reset = r; arm = a; trig_en = te; trig_pc = tp; stop = s; cap_valid = c;
    cap_pc = p; cap_result = res_of(p); rd_ready = rr;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, exp);
    end
  endtask
  task automatic chk_all(input string n, input logic [1:0] es, input logic [2:0] ec,
                         input logic ed, input logic [15:0] epc);
    logic ev;
    ev = ec != 0;
    chk(n, {state, count, dropped, rd_valid, rd_pc, rd_result},
        {es, ec, ed, ev, ev ? epc : 16'h0, ev ? res_of(epc) : 16'h0});
  endtask
  initial begin
    //  r  a  te tp      s  c  pc       rr  state cnt dr rv rd_pc
    add(1, 0, 0, 16'h0,  0, 0, 16'h0,   0,  0,    0,  0, 0, 16'h0);
    add(0, 1, 0, 16'h0,  0, 0, 16'h0,   0,  2,    0,  0, 0, 16'h0);
    add(0, 0, 0, 16'h0,  0, 1, 16'h0,   0,  2,    1,  0, 1, 16'h0);
    add(0, 0, 0, 16'h0,  0, 1, 16'h2,   0,  2,    2,  0, 1, 16'h0);
    add(0, 0, 0, 16'h0,  0, 1, 16'h4,   0,  2,    3,  0, 1, 16'h0);
    add(0, 0, 0, 16'h0,  0, 1, 16'h6,   0,  3,    4,  0, 1, 16'h0);
    add(0, 0, 0, 16'h0,  0, 1, 16'h8,   0,  3,    4,  1, 1, 16'h0);
    add(0, 1, 0, 16'h0,  0, 0, 16'h0,   0,  3,    4,  1, 1, 16'h0);
    add(0, 0, 0, 16'h0,  0, 0, 16'h0,   1,  3,    3,  1, 1, 16'h2);
    add(0, 0, 0, 16'h0,  0, 0, 16'h0,   1,  3,    2,  1, 1, 16'h4);
    add(0, 0, 0, 16'h0,  0, 0, 16'h0,   1,  3,    1,  1, 1, 16'h6);
    add(0, 0, 0, 16'h0,  0, 0, 16'h0,   1,  3,    0,  1, 0, 16'h0);
    add(0, 0, 0, 16'h0,  0, 0, 16'h0,   0,  0,    0,  1, 0, 16'h0);
    add(0, 1, 1, 16'h10, 0, 0, 16'h0,   0,  1,    0,  0, 0, 16'h0);
    add(0, 0, 0, 16'h10, 0, 1, 16'hC,   0,  1,    0,  0, 0, 16'h0);
    add(0, 0, 0, 16'h10, 0, 1, 16'hE,   0,  1,    0,  0, 0, 16'h0);
    add(0, 0, 0, 16'h10, 0, 1, 16'h10,  0,  2,    1,  0, 1, 16'h10);
    add(0, 0, 0, 16'h10, 0, 1, 16'h12,  0,  2,    2,  0, 1, 16'h10);
    add(1, 0, 0, 16'h0,  0, 1, 16'h14,  1,  0,    0,  0, 0, 16'h0);
    add(0, 1, 0, 16'h0,  0, 0, 16'h0,   0,  2,    0,  0, 0, 16'h0);
    foreach (v[i]) begin
      drive(v[i].r, v[i].a, v[i].te, v[i].tp, v[i].s, v[i].c, v[i].p, v[i].rr);
      chk_all($sformatf("vec%0d", i), v[i].es, v[i].ec, v[i].ed, v[i].epc);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h100, 0);
    chk_all("push1", 2, 1, 0, 16'h100);
    drive(0, 1, 1, 16'h100, 0, 0, 0, 0);
    chk_all("arm_busy", 2, 1, 0, 16'h100);
    drive(0, 0, 0, 0, 0, 1, 16'h102, 0);
    drive(0, 0, 0, 0, 0, 1, 16'h104, 0);
    chk_all("fill3", 2, 3, 0, 16'h100);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 0, 0, 1, 16'(16'h104 + 2 * k), 1);
      chk_all($sformatf("pushpop%0d", k), 2, 3, 0, 16'(16'h100 + 2 * k));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_all("pop_to2", 2, 2, 0, 16'h116);
    drive(0, 0, 0, 0, 1, 1, 16'h200, 0);
    chk_all("stop_wr", 3, 3, 0, 16'h116);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_all("drain1", 3, 2, 0, 16'h118);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_all("drain2", 3, 1, 0, 16'h200);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_all("drain3", 3, 0, 0, 16'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_all("idle", 0, 0, 0, 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
